vctrl_sequencer: RTL and testbench
==================================

Name: vctrl_sequencer

Overview:
- Registered, handshaked successor to the scalar opcode decoder in the RV64IV decode stage.
- Decodes the scalar classes plus the vector classes OP-V, LOAD-FP(V) and STORE-FP(V).
- Expands each vector instruction into one micro-op per register of its LMUL group.
- Sits between fetch/IF-ID and the ID/EX register; stalls upstream while a vector group is being issued.

Parameters:
- ENABLE_V, 1, 0: all vector opcodes decode as illegal.
- MAX_LMUL_LOG2, 3, maximum group size log2; groups are clamped to 2^MAX_LMUL_LOG2 uops (1..3 legal).
- IDX_W, 3, width of uop_idx; must be >= MAX_LMUL_LOG2 (minimum 1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous kill of the pending instruction/group
- in_valid  in  1  instruction available
- in_ready  out  1  sequencer accepts instruction this cycle
- instr  in  32  instruction word
- vlmul  in  3  vtype.vlmul from CSR, sampled at accept
- out_valid  out  1  uop valid
- out_ready  in  1  downstream accepts uop
- jmp, branch, memread, memtoreg, memwrite, alusrc, regwrite, regdst, jalr  out  1 each  scalar control bundle
- aluop  out  2  ALU class
- sign_select  out  3  immediate format
- vec  out  1  uop is vector
- vwrite  out  1  vector register-file write
- rd_o, rs1_o, rs2_o  out  5 each  register indices including group offset
- uop_idx  out  IDX_W  index within group
- uop_last  out  1  final uop of instruction
- illegal  out  1  instruction is illegal; all write/mem enables forced 0

Behaviour:
- Reset/flush: out_valid=0, state=IDLE, every output 0. Flush has priority over the handshake. Reset or flush mid-group drops remaining uops; no partial uop is presented afterwards.
- in_ready = (state==IDLE) && (!out_valid || (out_ready && uop_last)). Back-to-back scalar throughput is 1/cycle.
- Accept when in_valid && in_ready. The first uop is registered and out_valid=1 the next cycle (latency 1). Outputs are held stable while out_valid && !out_ready.
- States:
  - IDLE→ISSUE on accept of an instruction with G>1.
  - ISSUE: on each out_ready, uop_idx++ and rd/rs offsets are recomputed.
  - ISSUE→IDLE when the uop with uop_last is consumed.
  - With G==1 the state stays IDLE.
- Group size G: vlmul 000/001/010/011 → 1/2/4/8, clamped to 2^MAX_LMUL_LOG2. Fractional 101/110/111 → 1. Reserved 100 → illegal, G=1. Scalar instructions → G=1. uop_last = (uop_idx==G-1).
- Scalar decode, opcode → {jmp,branch,memread,memtoreg,memwrite,alusrc,regwrite,regdst,jalr,aluop,sign_select}:
  - 0110011 → 0,0,0,0,0,0,1,0,0,10,000
  - 0010011 → 0,0,0,0,0,1,1,0,0,11,000
  - 0000011 → 0,0,1,1,0,1,1,0,0,00,000
  - 1100111 → 0,0,0,0,0,1,1,0,1,00,000
  - 1100011 → 0,1,0,0,0,0,0,0,0,01,011
  - 0100011 → 0,0,0,0,1,1,0,1,0,00,001
  - 1101111 → 1,0,0,0,0,0,1,0,0,00,000
- Vector decode:
  - OP-V 1010111, funct3 != 111: vec=1, vwrite=1, aluop=10, alusrc=(funct3 in {011,100}).
  - OP-V 1010111, funct3 == 111 (vsetvl*): scalar, G=1, regwrite=1, aluop=11.
  - 0000111 with funct3 in {000,101,110,111}: vec=1, memread=1, memtoreg=1, vwrite=1, alusrc=1, aluop=00.
  - 0100111 with the same funct3 set: vec=1, memwrite=1, regdst=1, alusrc=1, sign_select=001.
  - Other funct3 under 0000111/0100111 → illegal.
- Operand offsets (5-bit adds; misalignment is caught as illegal before any wrap):
  - Vector: rd_o = rd + uop_idx.
  - OP-V: rs2_o = rs2 + uop_idx.
  - OP-V funct3 in {000,001,010} (.vv forms): rs1_o = rs1 + uop_idx.
  - Everything else passes through unchanged.
- Alignment: for G>1, any offset field that is not a multiple of G → illegal, G=1.
- Unknown opcode, or ENABLE_V=0 with a vector opcode → illegal=1, all bundle bits 0, G=1, still presented as one uop.

Test Plan:
- Reset: rst=1 two cycles with in_valid=1 → out_valid=0, in_ready=0 during reset, all outputs 0. After release, in_ready=1.
- Scalar stream: add, lw, sw, jal on consecutive cycles, out_ready=1 → 4 uops on cycles N+1..N+4 with the bundle values above and uop_last=1 on each.
- vadd.vv v8,v16,v24 with vlmul=010 → 4 uops, rd_o=8..11, rs2_o=16..19, rs1_o=24..27, uop_idx 0..3, uop_last only on idx 3. in_ready=0 until the last uop is consumed.
- Backpressure: vle64 v4 (vlmul=001) with out_ready toggling 0/1 → outputs held stable while stalled, exactly 2 uops, rd_o 4 then 5, memread=1.
- Illegal: vadd.vv v9 with vlmul=001 (misaligned); vlmul=100; opcode 1111111 → each gives a single uop with illegal=1, regwrite=vwrite=memwrite=0.
- Flush during the idx=1 uop of an 8-uop group → next cycle out_valid=0, in_ready=1; the following scalar instruction issues normally.

Source files
------------

// File: rtl/vctrl_sequencer.sv
// Registered RV64IV decode stage: decodes scalar and vector instruction classes
// and expands each vector instruction into one micro-op per LMUL group register.
module vctrl_sequencer #(
    parameter bit          ENABLE_V      = 1'b1,
    parameter int unsigned MAX_LMUL_LOG2 = 3,
    parameter int unsigned IDX_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       vlmul,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             jmp,
    output logic             branch,
    output logic             memread,
    output logic             memtoreg,
    output logic             memwrite,
    output logic             alusrc,
    output logic             regwrite,
    output logic             regdst,
    output logic             jalr,
    output logic [1:0]       aluop,
    output logic [2:0]       sign_select,
    output logic             vec,
    output logic             vwrite,
    output logic [4:0]       rd_o,
    output logic [4:0]       rs1_o,
    output logic [4:0]       rs2_o,
    output logic [IDX_W-1:0] uop_idx,
    output logic             uop_last,
    output logic             illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_V      = 7'b1010111;
    localparam logic [6:0] OP_VL     = 7'b0000111;
    localparam logic [6:0] OP_VS     = 7'b0100111;
    localparam logic [1:0] MAX_GLOG  = 2'(MAX_LMUL_LOG2);

    typedef enum logic {IDLE, ISSUE} state_t;

    typedef struct packed {
        logic       jmp;
        logic       branch;
        logic       memread;
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regwrite;
        logic       regdst;
        logic       jalr;
        logic [1:0] aluop;
        logic [2:0] sign_select;
        logic       vec;
        logic       vwrite;
        logic       illegal;
    } ctrl_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_f, rs1_f, rs2_f;
    logic       mem_width_ok;
    logic       unused_bits;

    assign opcode       = instr[6:0];
    assign rd_f         = instr[11:7];
    assign funct3       = instr[14:12];
    assign rs1_f        = instr[19:15];
    assign rs2_f        = instr[24:20];
    assign mem_width_ok = (funct3 == 3'b000) || (funct3[2] && (funct3 != 3'b100));
    assign unused_bits  = &{1'b0, instr[31:25]};

    state_t           state_q, state_d;
    ctrl_t            dec, ctrl_q, ctrl_d;
    logic [2:0]       dec_off, off_q, off_d;   // {rd, rs1, rs2} gets group offset
    logic [1:0]       dec_glog;
    logic             dec_vgrp, dec_bad;
    logic [4:0]       align_mask;
    logic [IDX_W-1:0] dec_last_idx;
    logic             valid_q, valid_d, last_q, last_d;
    logic [IDX_W-1:0] idx_q, idx_d, last_idx_q, last_idx_d, idx_inc;
    logic [4:0]       base_rd_q, base_rs1_q, base_rs2_q;
    logic [4:0]       base_rd_d, base_rs1_d, base_rs2_d;
    logic [4:0]       rd_q, rs1_q, rs2_q, rd_d, rs1_d, rs2_d;
    logic             accept, consume;

    assign in_ready = !rst && !flush && (state_q == IDLE) && (!valid_q || (out_ready && last_q));
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // Instruction decode: control bundle, group size, offset fields, legality
    always_comb begin
        dec        = '0;
        dec_off    = '0;
        dec_glog   = '0;
        dec_vgrp   = 1'b0;
        dec_bad    = 1'b0;
        align_mask = '0;
        case (opcode)
            OP_R:      begin dec.regwrite = 1'b1; dec.aluop = 2'b10; end
            OP_IMM:    begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11; end
            OP_LOAD:   begin dec.memread = 1'b1; dec.memtoreg = 1'b1; dec.alusrc = 1'b1; dec.regwrite = 1'b1; end
            OP_JALR:   begin dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.jalr = 1'b1; end
            OP_BRANCH: begin dec.branch = 1'b1; dec.aluop = 2'b01; dec.sign_select = 3'b011; end
            OP_STORE:  begin dec.memwrite = 1'b1; dec.alusrc = 1'b1; dec.regdst = 1'b1; dec.sign_select = 3'b001; end
            OP_JAL:    begin dec.jmp = 1'b1; dec.regwrite = 1'b1; end
            OP_V: begin
                if (!ENABLE_V) begin
                    dec_bad = 1'b1;
                end else if (funct3 == 3'b111) begin
                    dec.regwrite = 1'b1;
                    dec.aluop    = 2'b11;
                end else begin
                    dec.vec    = 1'b1;
                    dec.vwrite = 1'b1;
                    dec.aluop  = 2'b10;
                    dec.alusrc = (funct3 == 3'b011) || (funct3 == 3'b100);
                    dec_off    = {1'b1, (funct3 <= 3'b010), 1'b1};
                    dec_vgrp   = 1'b1;
                end
            end
            OP_VL: begin
                if (!ENABLE_V || !mem_width_ok) begin
                    dec_bad = 1'b1;
                end else begin
                    dec.vec      = 1'b1;
                    dec.memread  = 1'b1;
                    dec.memtoreg = 1'b1;
                    dec.vwrite   = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec_off      = 3'b100;
                    dec_vgrp     = 1'b1;
                end
            end
            OP_VS: begin
                if (!ENABLE_V || !mem_width_ok) begin
                    dec_bad = 1'b1;
                end else begin
                    dec.vec         = 1'b1;
                    dec.memwrite    = 1'b1;
                    dec.regdst      = 1'b1;
                    dec.alusrc      = 1'b1;
                    dec.sign_select = 3'b001;
                    dec_off         = 3'b100;
                    dec_vgrp        = 1'b1;
                end
            end
            default: dec_bad = 1'b1;
        endcase
        if (dec_vgrp) begin
            if (vlmul == 3'b100) begin
                dec_bad = 1'b1;
            end else if (!vlmul[2]) begin
                dec_glog = (vlmul[1:0] > MAX_GLOG) ? MAX_GLOG : vlmul[1:0];
            end
        end
        // Offset fields must be group-aligned so the 5-bit adds never wrap
        align_mask = (5'd1 << dec_glog) - 5'd1;
        if ((dec_off[2] && ((rd_f & align_mask) != 5'd0)) ||
            (dec_off[1] && ((rs1_f & align_mask) != 5'd0)) ||
            (dec_off[0] && ((rs2_f & align_mask) != 5'd0))) begin
            dec_bad = 1'b1;
        end
        if (dec_bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            dec_off     = '0;
            dec_glog    = '0;
        end
    end

    assign dec_last_idx = IDX_W'((4'd1 << dec_glog) - 4'd1);
    assign idx_inc      = idx_q + IDX_W'(1);

    // Next-state and next-uop computation
    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        ctrl_d     = ctrl_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        last_d     = last_q;
        off_d      = off_q;
        base_rd_d  = base_rd_q;
        base_rs1_d = base_rs1_q;
        base_rs2_d = base_rs2_q;
        rd_d       = rd_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        if (flush) begin
            state_d    = IDLE;
            valid_d    = 1'b0;
            ctrl_d     = '0;
            idx_d      = '0;
            last_idx_d = '0;
            last_d     = 1'b0;
            off_d      = '0;
            base_rd_d  = '0;
            base_rs1_d = '0;
            base_rs2_d = '0;
            rd_d       = '0;
            rs1_d      = '0;
            rs2_d      = '0;
        end else if (accept) begin
            state_d    = (dec_glog != 2'd0) ? ISSUE : IDLE;
            valid_d    = 1'b1;
            ctrl_d     = dec;
            idx_d      = '0;
            last_idx_d = dec_last_idx;
            last_d     = (dec_glog == 2'd0);
            off_d      = dec_off;
            base_rd_d  = rd_f;
            base_rs1_d = rs1_f;
            base_rs2_d = rs2_f;
            rd_d       = rd_f;
            rs1_d      = rs1_f;
            rs2_d      = rs2_f;
        end else if (consume) begin
            if (last_q) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end else begin
                idx_d  = idx_inc;
                last_d = (idx_inc == last_idx_q);
                rd_d   = base_rd_q  + (off_q[2] ? 5'(idx_inc) : 5'd0);
                rs1_d  = base_rs1_q + (off_q[1] ? 5'(idx_inc) : 5'd0);
                rs2_d  = base_rs2_q + (off_q[0] ? 5'(idx_inc) : 5'd0);
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Uop output and group-tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            last_q     <= 1'b0;
            off_q      <= '0;
            base_rd_q  <= '0;
            base_rs1_q <= '0;
            base_rs2_q <= '0;
            rd_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            last_q     <= last_d;
            off_q      <= off_d;
            base_rd_q  <= base_rd_d;
            base_rs1_q <= base_rs1_d;
            base_rs2_q <= base_rs2_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
        end
    end

    assign out_valid   = valid_q;
    assign jmp         = ctrl_q.jmp;
    assign branch      = ctrl_q.branch;
    assign memread     = ctrl_q.memread;
    assign memtoreg    = ctrl_q.memtoreg;
    assign memwrite    = ctrl_q.memwrite;
    assign alusrc      = ctrl_q.alusrc;
    assign regwrite    = ctrl_q.regwrite;
    assign regdst      = ctrl_q.regdst;
    assign jalr        = ctrl_q.jalr;
    assign aluop       = ctrl_q.aluop;
    assign sign_select = ctrl_q.sign_select;
    assign vec         = ctrl_q.vec;
    assign vwrite      = ctrl_q.vwrite;
    assign illegal     = ctrl_q.illegal;
    assign rd_o        = rd_q;
    assign rs1_o       = rs1_q;
    assign rs2_o       = rs2_q;
    assign uop_idx     = idx_q;
    assign uop_last    = last_q;

endmodule

// File: tb/tb_vctrl_sequencer.sv
// Scoreboard bench for vctrl_sequencer: expected uops are queued at accept and
// compared by an independent monitor whenever the DUT presents a uop.
module tb_vctrl_sequencer;

    localparam int MAXG = 8;

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr;
    logic [2:0]  vlmul;
    logic        jmp, branch, memread, memtoreg, memwrite, alusrc, regwrite, regdst, jalr;
    logic [1:0]  aluop;
    logic [2:0]  sign_select;
    logic        vec, vwrite, illegal, uop_last;
    logic [4:0]  rd_o, rs1_o, rs2_o;
    logic [2:0]  uop_idx;

    vctrl_sequencer #(.ENABLE_V(1'b1), .MAX_LMUL_LOG2(3), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .vlmul(vlmul),
        .out_valid(out_valid), .out_ready(out_ready),
        .jmp(jmp), .branch(branch), .memread(memread), .memtoreg(memtoreg),
        .memwrite(memwrite), .alusrc(alusrc), .regwrite(regwrite), .regdst(regdst),
        .jalr(jalr), .aluop(aluop), .sign_select(sign_select),
        .vec(vec), .vwrite(vwrite), .rd_o(rd_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
        .uop_idx(uop_idx), .uop_last(uop_last), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [13:0] ctl;   // jmp,branch,memread,memtoreg,memwrite,alusrc,regwrite,regdst,jalr,aluop,sign_select
        logic        vec;
        logic        vwrite;
        logic        ill;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  idx;
        logic        last;
    } uop_t;

    typedef struct packed {
        uop_t u;
        logic single;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          guard;
    logic [35:0] act;

    assign act = {jmp, branch, memread, memtoreg, memwrite, alusrc, regwrite, regdst, jalr,
                  aluop, sign_select, vec, vwrite, illegal, rd_o, rs1_o, rs2_o, uop_idx, uop_last};

    task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, a, e, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        return {7'b0, rs2, rs1, f3, rd, op};
    endfunction

    // Reference model: expand one accepted instruction into its expected uops
    task automatic push_model(input logic [31:0] ins, input logic [2:0] vl);
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [13:0] ctl;
        bit          vecop, vw, ill, ofd, of1, of2, memf3;
        int          g;
        exp_t        e;
        f3  = ins[14:12];
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        ctl = '0;
        vecop = 0; vw = 0; ill = 0; ofd = 0; of1 = 0; of2 = 0;
        g = 1;
        memf3 = (f3 == 3'd0) || (f3 >= 3'd5);
        case (ins[6:0])
            7'b0110011: ctl = {9'b000000100, 2'b10, 3'b000};
            7'b0010011: ctl = {9'b000001100, 2'b11, 3'b000};
            7'b0000011: ctl = {9'b001101100, 2'b00, 3'b000};
            7'b1100111: ctl = {9'b000001101, 2'b00, 3'b000};
            7'b1100011: ctl = {9'b010000000, 2'b01, 3'b011};
            7'b0100011: ctl = {9'b000011010, 2'b00, 3'b001};
            7'b1101111: ctl = {9'b100000100, 2'b00, 3'b000};
            7'b1010111: begin
                if (f3 == 3'd7) begin
                    ctl = {9'b000000100, 2'b11, 3'b000};
                end else begin
                    vecop = 1; vw = 1; ofd = 1; of2 = 1;
                    of1 = (f3 <= 3'd2);
                    ctl = {5'b00000, 1'((f3 == 3'd3) || (f3 == 3'd4)), 3'b000, 2'b10, 3'b000};
                end
            end
            7'b0000111: begin
                if (!memf3) ill = 1;
                else begin vecop = 1; vw = 1; ofd = 1; ctl = {9'b001101000, 2'b00, 3'b000}; end
            end
            7'b0100111: begin
                if (!memf3) ill = 1;
                else begin vecop = 1; ofd = 1; ctl = {9'b000011010, 2'b00, 3'b001}; end
            end
            default: ill = 1;
        endcase
        if (vecop) begin
            if (vl == 3'b100) ill = 1;
            else if (!vl[2]) begin
                g = 1 << vl[1:0];
                if (g > MAXG) g = MAXG;
            end
            if (!ill && g > 1 && ((ofd && int'(rd) % g != 0) ||
                                  (of1 && int'(rs1) % g != 0) ||
                                  (of2 && int'(rs2) % g != 0))) ill = 1;
        end
        if (ill) begin
            ctl = '0; vecop = 0; vw = 0; g = 1; ofd = 0; of1 = 0; of2 = 0;
        end
        for (int k = 0; k < g; k++) begin
            e.u.ctl    = ctl;
            e.u.vec    = vecop;
            e.u.vwrite = vw;
            e.u.ill    = ill;
            e.u.rd     = rd  + (ofd ? 5'(k) : 5'd0);
            e.u.rs1    = rs1 + (of1 ? 5'(k) : 5'd0);
            e.u.rs2    = rs2 + (of2 ? 5'(k) : 5'd0);
            e.u.idx    = 3'(k);
            e.u.last   = (k == g - 1);
            e.single   = (g == 1);
            sb.push_back(e);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] op;
        logic [4:0] m, rd, rs1, rs2;
        case ($urandom_range(0, 13))
            0:       op = 7'b0110011;
            1:       op = 7'b0010011;
            2:       op = 7'b0000011;
            3:       op = 7'b1100111;
            4:       op = 7'b1100011;
            5:       op = 7'b0100011;
            6:       op = 7'b1101111;
            7, 8:    op = 7'b1010111;
            9, 10:   op = 7'b0000111;
            11, 12:  op = 7'b0100111;
            default: op = 7'b1111111;
        endcase
        case ($urandom_range(0, 3))
            0:       m = 5'b11111;
            1:       m = 5'b11110;
            2:       m = 5'b11100;
            default: m = 5'b11000;
        endcase
        rd  = 5'($urandom) & m;
        rs1 = 5'($urandom) & m;
        rs2 = 5'($urandom) & m;
        return {7'($urandom), rs2, rs1, 3'($urandom), rd, op};
    endfunction

    // Monitor: compare presented uop with scoreboard head, track handshakes
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                check("rst_out_valid", 64'(out_valid), 64'(0));
                check("rst_in_ready", 64'(in_ready), 64'(0));
                check("rst_outputs", 64'(act), 64'(0));
            end else if (flush) begin
                sb.delete();
            end else begin
                check("out_valid", 64'(out_valid), 64'(sb.size() != 0));
                check("in_ready", 64'(in_ready),
                      64'((sb.size() == 0) || (sb.size() == 1 && sb[0].single && out_ready)));
                if (out_valid && sb.size() != 0) begin
                    check("uop", 64'(act), 64'(sb[0].u));
                    if (out_ready) void'(sb.pop_front());
                end
                if (in_valid && in_ready) push_model(instr, vlmul);
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] ins, input logic [2:0] vl,
                         input bit ordy, input bit fl);
        in_valid  = v;
        instr     = ins;
        vlmul     = vl;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] i_add, i_lw, i_sw, i_jal, i_vadd8, i_vadd9, i_vle4, i_bad, i_vgrp8;

    initial begin
        i_add   = mk(7'b0110011, 5'd1, 3'b000, 5'd2, 5'd3);
        i_lw    = mk(7'b0000011, 5'd5, 3'b010, 5'd2, 5'd0);
        i_sw    = mk(7'b0100011, 5'd4, 3'b010, 5'd2, 5'd6);
        i_jal   = mk(7'b1101111, 5'd1, 3'b000, 5'd0, 5'd0);
        i_vadd8 = mk(7'b1010111, 5'd8, 3'b000, 5'd24, 5'd16);
        i_vadd9 = mk(7'b1010111, 5'd9, 3'b000, 5'd24, 5'd16);
        i_vle4  = mk(7'b0000111, 5'd4, 3'b111, 5'd10, 5'd0);
        i_bad   = mk(7'b1111111, 5'd1, 3'b000, 5'd2, 5'd3);
        i_vgrp8 = mk(7'b1010111, 5'd0, 3'b000, 5'd16, 5'd8);

        rst = 1'b1;
        drive(1, i_add, 3'b000, 1, 0);
        drive(1, i_add, 3'b000, 1, 0);
        rst = 1'b0;

        // back-to-back scalar stream
        drive(1, i_add, 3'b000, 1, 0);
        drive(1, i_lw,  3'b000, 1, 0);
        drive(1, i_sw,  3'b000, 1, 0);
        drive(1, i_jal, 3'b000, 1, 0);
        drive(0, i_add, 3'b000, 1, 0);

        // LMUL=4 .vv group
        drive(1, i_vadd8, 3'b010, 1, 0);
        for (int i = 0; i < 6; i++) drive(0, i_add, 3'b000, 1, 0);

        // backpressure on a two-uop vector load
        drive(1, i_vle4, 3'b001, 0, 0);
        for (int i = 0; i < 8; i++) drive(0, i_add, 3'b000, 1'(i % 2), 0);
        drive(0, i_add, 3'b000, 1, 0);

        // illegal cases
        drive(1, i_vadd9, 3'b001, 1, 0);
        drive(1, i_vadd8, 3'b100, 1, 0);
        drive(1, i_bad,   3'b000, 1, 0);
        drive(0, i_add,   3'b000, 1, 0);

        // flush while idx=1 of an eight-uop group is presented
        drive(1, i_vgrp8, 3'b011, 0, 0);
        drive(0, i_add, 3'b000, 0, 0);
        drive(0, i_add, 3'b000, 1, 0);
        drive(0, i_add, 3'b000, 0, 1);
        flush = 1'b0;
        #1;
        check("post_flush_out_valid", 64'(out_valid), 64'(0));
        check("post_flush_in_ready", 64'(in_ready), 64'(1));
        drive(1, i_add, 3'b000, 1, 0);
        drive(0, i_add, 3'b000, 1, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            automatic bit fl = ($urandom_range(0, 63) == 0);
            drive(fl ? 1'b0 : ($urandom_range(0, 9) < 7), rand_instr(), 3'($urandom),
                  ($urandom_range(0, 3) != 0), fl);
        end

        // drain with a bounded wait
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while ((sb.size() != 0 || out_valid) && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_scoreboard_empty", 64'(sb.size()), 64'(0));
        check("drain_out_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
